// File: rtl/uart_rx.sv
// UART receiver: start/data/optional parity/stop framing, majority-of-three sampling per bit.
// Latency: result pulses (2+DATA_WIDTH+parity)*P-1 cycles after start detection; no backpressure.
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic [PRESC_WIDTH-1:0] Prescale,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    output logic [DATA_WIDTH-1:0]  P_DATA,
    output logic                   Data_Valid,
    output logic                   Par_Err,
    output logic                   Stop_Err
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESC_WIDTH-1:0] ONE = PRESC_WIDTH'(1);
    localparam logic [PRESC_WIDTH-1:0] P8  = PRESC_WIDTH'(8);
    localparam logic [PRESC_WIDTH-1:0] P16 = PRESC_WIDTH'(16);
    localparam logic [PRESC_WIDTH-1:0] P32 = PRESC_WIDTH'(32);
    localparam logic [BW-1:0]          LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nxt;

    logic [PRESC_WIDTH-1:0] presc, presc_in, half, edge_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  shreg;
    logic                   par_en_l, par_typ_l;
    logic                   s0, s1, bit_val, par_flag;
    logic                   bit_end, smp0, smp1, smp2, last_bit, maj, par_bad;

    // Any unsupported oversampling ratio falls back to 8.
    assign presc_in = (Prescale == P16 || Prescale == P32) ? Prescale : P8;
    assign half     = presc >> 1;
    assign smp0     = (edge_cnt == half - ONE);
    assign smp1     = (edge_cnt == half);
    assign smp2     = (edge_cnt == half + ONE);
    assign bit_end  = (edge_cnt == presc - ONE);
    assign last_bit = (bit_cnt == LAST_BIT);
    assign maj      = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
    assign par_bad  = bit_val != ((^shreg) ^ par_typ_l);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!RX_IN) state_nxt = START;
            START:   if (bit_end) state_nxt = bit_val ? IDLE : DATA;
            DATA:    if (bit_end && last_bit) state_nxt = par_en_l ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            presc      <= '0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            bit_val    <= 1'b0;
            par_flag   <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
            if (state == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                par_flag <= 1'b0;
                // The detection cycle itself is edge 0 of the start bit.
                if (!RX_IN) begin
                    edge_cnt  <= ONE;
                    presc     <= presc_in;
                    par_en_l  <= PAR_EN;
                    par_typ_l <= PAR_TYP;
                end
            end else begin
                edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
                if (smp0) s0 <= RX_IN;
                if (smp1) s1 <= RX_IN;
                if (smp2) bit_val <= maj;
                if (bit_end) begin
                    case (state)
                        DATA: begin
                            shreg[bit_cnt] <= bit_val;
                            bit_cnt        <= last_bit ? '0 : bit_cnt + BW'(1);
                        end
                        PARITY: par_flag <= par_bad;
                        STOP: begin
                            Stop_Err   <= !bit_val;
                            Par_Err    <= par_flag;
                            Data_Valid <= bit_val && !par_flag;
                            if (bit_val && !par_flag) P_DATA <= shreg;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, meaning number of data bits per frame.
REQ-002 Parameter PRESC_WIDTH, default 6, meaning width of the Prescale input.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset is synchronous and active-low.
REQ-005 RX_IN  input  1  serial line; idle high; driven synchronous to CLK, no internal synchronizer.
REQ-006 Prescale  input  PRESC_WIDTH  oversampling ratio, CLK cycles per bit; legal values 8, 16, 32.
REQ-007 PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 P_DATA  output  DATA_WIDTH  last received data word, LSB received first.
REQ-010 Data_Valid  output  1  one-cycle pulse; P_DATA holds a new error-free word.
REQ-011 Par_Err  output  1  one-cycle pulse; parity mismatch on the frame just ended.
REQ-012 Stop_Err  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; frame format: start(0), DATA_WIDTH data bits LSB first, optional parity, one stop(1), matching UART_TX framing.
REQ-014 An edge counter SHALL count 0..Prescale-1 within each bit; a bit counter SHALL count data bits 0..DATA_WIDTH-1.
REQ-015 Prescale value other than 16 or 32 SHALL be treated as 8; Prescale, PAR_EN, PAR_TYP SHALL be latched on the start-detection cycle and held for the frame.
REQ-016 IDLE: RX_IN==0 -> START; that cycle is edge count 0 of the start bit.
REQ-017 Each bit SHALL be sampled at edge counts P/2-1, P/2, P/2+1 (P = latched Prescale); bit value = majority of the three samples.
REQ-018 A bit period SHALL end at edge count P-1, when the edge counter wraps to 0 and the next state is entered.
REQ-019 START: resolved start bit 1 (glitch) -> IDLE at bit end with no outputs asserted; else -> DATA.
REQ-020 DATA: resolved bits shift into an internal register at position bit counter; after bit DATA_WIDTH-1 -> PARITY if PAR_EN else STOP.
REQ-021 PARITY: expected = XOR of data bits (even), inverted when PAR_TYP=1; mismatch recorded; -> STOP.
REQ-022 STOP: at the bit end -> IDLE and SHALL, in that single cycle, pulse Stop_Err if stop resolved 0 and Par_Err if parity mismatch recorded.
REQ-023 Data_Valid SHALL pulse in the same cycle only if neither error pulses; P_DATA SHALL update only with Data_Valid and otherwise hold.
REQ-024 Latency: Data_Valid at cycle (2+DATA_WIDTH+PAR_EN)*P-1 after the start-detection cycle.
REQ-025 Back-to-back frames: RX_IN low in the first IDLE cycle after STOP SHALL be detected as a new start with no lost cycle.
REQ-026 RX_IN activity during DATA/PARITY/STOP SHALL not restart the frame; only the sample points matter.

Reset
REQ-027 RST==0 at a rising CLK edge SHALL force IDLE, clear all counters, parity/error flags and P_DATA to 0, and Data_Valid, Par_Err, Stop_Err to 0, including mid-frame.
REQ-028 After reset release, reception SHALL start only on a subsequent RX_IN low in IDLE.

Verification
REQ-029 Prescale=8, PAR_EN=0, send 0xA5 -> one Data_Valid at cycle 79 after start detect, P_DATA=0xA5, no errors.
REQ-030 Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> Data_Valid, P_DATA=0x3C; same with parity 1 -> Par_Err pulse, no Data_Valid, P_DATA unchanged.
REQ-031 Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x01, stop bit 0 -> Stop_Err pulse, no Data_Valid; next frame 0x80 correct -> Data_Valid, P_DATA=0x80.
REQ-032 Prescale=8, RX_IN low for 3 cycles then high -> return to IDLE after 8 cycles, no output pulses; following valid 0x55 received correctly.
REQ-033 Two frames 0xFF, 0x00 back-to-back at Prescale=16 -> two Data_Valid pulses exactly 160 cycles apart.
REQ-034 RST low during DATA bit 4 then valid frame 0x99 -> all outputs 0 during reset, next frame P_DATA=0x99 with Data_Valid.
